// File: rtl/branch_resolve_queue_if.sv
// ============================================================================
// Module   : branch_resolve_queue_if
// Purpose  : Bundles the fetch-push, execute-resolve, queue-status, BTB-write
//            and redirect signals of branch_resolve_queue.
//            master : fetch/execute side (drives i_*, observes o_*)
//            slave  : the queue itself (observes i_*, drives o_*)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface branch_resolve_queue_if #(
  parameter int DEPTH       = 4,
  parameter int N           = 4,
  parameter int INDEX_WIDTH = 2,
  parameter int BIA_WIDTH   = 60,
  parameter int ADDR_WIDTH  = 64
);
  localparam int c_WAY_W = $clog2(N);
  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  // fetch push
  logic                   i_push;
  logic [ADDR_WIDTH-1:0]  i_push_pc;
  logic                   i_push_hit;
  logic [c_WAY_W-1:0]     i_push_way;
  logic [ADDR_WIDTH-1:0]  i_push_pred_target;
  // execute resolve
  logic                   i_resolve;
  logic                   i_is_branch;
  logic                   i_taken;
  logic [ADDR_WIDTH-1:0]  i_actual_target;
  // queue status
  logic                   o_full;
  logic                   o_empty;
  logic [c_CNT_W-1:0]     o_count;
  // BTB write
  logic                   o_btb_update;
  logic [ADDR_WIDTH-1:0]  o_target_addr;
  logic [c_WAY_W-1:0]     o_way_write;
  logic [BIA_WIDTH-1:0]   o_bia_write;
  logic [INDEX_WIDTH-1:0] o_index_write;
  // PC-select redirect
  logic                   o_mispredict;
  logic [ADDR_WIDTH-1:0]  o_redirect_pc;

  modport master (
    output i_push, i_push_pc, i_push_hit, i_push_way, i_push_pred_target,
    output i_resolve, i_is_branch, i_taken, i_actual_target,
    input  o_full, o_empty, o_count,
    input  o_btb_update, o_target_addr, o_way_write, o_bia_write, o_index_write,
    input  o_mispredict, o_redirect_pc
  );

  modport slave (
    input  i_push, i_push_pc, i_push_hit, i_push_way, i_push_pred_target,
    input  i_resolve, i_is_branch, i_taken, i_actual_target,
    output o_full, o_empty, o_count,
    output o_btb_update, o_target_addr, o_way_write, o_bia_write, o_index_write,
    output o_mispredict, o_redirect_pc
  );
endinterface

`default_nettype wire

// File: rtl/branch_resolve_queue.sv
// ============================================================================
// Module   : branch_resolve_queue
// Purpose  : In-order queue of BTB lookup metadata (one entry per fetched
//            instruction). Fetch pushes {pc, hit, way, predicted target};
//            execute pops the head on resolution, which produces the BTB
//            write (1-cycle latency) and a one-cycle mispredict/redirect.
// Ports    : i_clk     - clock, rising edge
//            i_arst_n  - asynchronous reset, active-low
//            i_flush   - drop all queued entries
//            i_stall   - blocks resolve, holds pending BTB update
//            bus       - branch_resolve_queue_if.slave (push/resolve inputs,
//                        status, BTB write and redirect outputs)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve_queue #(
  parameter int DEPTH       = 4,
  parameter int N           = 4,
  parameter int INDEX_WIDTH = 2,
  parameter int BIA_WIDTH   = 60,
  parameter int ADDR_WIDTH  = 64
) (
  input  logic                  i_clk,
  input  logic                  i_arst_n,
  input  logic                  i_flush,
  input  logic                  i_stall,
  branch_resolve_queue_if.slave bus
);
  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_WAY_W = $clog2(N);

  // entry storage (no reset needed: validity is tracked by the pointers)
  logic [ADDR_WIDTH-1:0] r_pc   [DEPTH];
  logic [ADDR_WIDTH-1:0] r_pred [DEPTH];
  logic [c_WAY_W-1:0]    r_way  [DEPTH];
  logic [DEPTH-1:0]      r_hit;

  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_CNT_W-1:0]    r_count;

  logic                   r_btb_update;
  logic [ADDR_WIDTH-1:0]  r_target_addr;
  logic [c_WAY_W-1:0]     r_way_write;
  logic [BIA_WIDTH-1:0]   r_bia_write;
  logic [INDEX_WIDTH-1:0] r_index_write;
  logic                   r_mispredict;
  logic [ADDR_WIDTH-1:0]  r_redirect_pc;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_br_taken;
  logic                  w_mis_now;
  logic [ADDR_WIDTH-1:0] w_head_pc;
  logic [ADDR_WIDTH-1:0] w_head_pred;
  logic [c_WAY_W-1:0]    w_head_way;
  logic                  w_head_hit;
  logic [ADDR_WIDTH-1:0] w_redirect;

  assign w_full      = (r_count == c_CNT_W'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_head_pc   = r_pc[r_rd_ptr];
  assign w_head_pred = r_pred[r_rd_ptr];
  assign w_head_way  = r_way[r_rd_ptr];
  assign w_head_hit  = r_hit[r_rd_ptr];

  assign w_pop      = bus.i_resolve & ~w_empty & ~i_stall;
  assign w_br_taken = bus.i_is_branch & bus.i_taken;

  // A BTB hit means "predicted taken"; a hit on a non-branch is an aliased
  // entry that steered fetch down a bogus path.
  always_comb begin
    w_mis_now = 1'b0;
    if (w_pop) begin
      if (bus.i_is_branch) begin
        w_mis_now = (bus.i_taken != w_head_hit) |
                    (bus.i_taken & w_head_hit & (bus.i_actual_target != w_head_pred));
      end else begin
        w_mis_now = w_head_hit;
      end
    end
  end

  // Younger entries are wrong-path once a mispredict is detected, so a push
  // in that cycle is dropped along with them.
  assign w_push = bus.i_push & ~w_full & ~i_flush & ~w_mis_now;

  assign w_redirect = w_br_taken ? bus.i_actual_target
                                 : w_head_pc + ADDR_WIDTH'(4);

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush | w_mis_now) begin
      // Empty the queue by catching the read pointer up to the write pointer.
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_pc[r_wr_ptr]   <= bus.i_push_pc;
      r_pred[r_wr_ptr] <= bus.i_push_pred_target;
      r_way[r_wr_ptr]  <= bus.i_push_way;
      r_hit[r_wr_ptr]  <= bus.i_push_hit;
    end
  end

  // BTB write port. Under stall the BTB ignores writes, so a pending update
  // is held until the pipeline moves again.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_btb_update  <= 1'b0;
      r_target_addr <= '0;
      r_way_write   <= '0;
      r_bia_write   <= '0;
      r_index_write <= '0;
    end else if (w_pop & w_br_taken) begin
      r_btb_update  <= 1'b1;
      r_target_addr <= bus.i_actual_target;
      r_way_write   <= w_head_way;
      r_bia_write   <= w_head_pc[ADDR_WIDTH-1 -: BIA_WIDTH];
      r_index_write <= w_head_pc[ADDR_WIDTH-BIA_WIDTH-1 -: INDEX_WIDTH];
    end else if (!i_stall) begin
      r_btb_update  <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_mispredict  <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_mispredict <= w_mis_now;
      if (w_mis_now) r_redirect_pc <= w_redirect;
    end
  end

  assign bus.o_full        = w_full;
  assign bus.o_empty       = w_empty;
  assign bus.o_count       = r_count;
  assign bus.o_btb_update  = r_btb_update;
  assign bus.o_target_addr = r_target_addr;
  assign bus.o_way_write   = r_way_write;
  assign bus.o_bia_write   = r_bia_write;
  assign bus.o_index_write = r_index_write;
  assign bus.o_mispredict  = r_mispredict;
  assign bus.o_redirect_pc = r_redirect_pc;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_queue.sv
// ============================================================================
// Module   : tb_branch_resolve_queue
// Purpose  : Self-checking bench for branch_resolve_queue: a table of
//            per-cycle stimulus with hand-computed expected outputs, plus
//            hand-written flush+resolve and reset-mid-resolve sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_resolve_queue;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic stall = 1'b0;

  always #5 clk = ~clk;

  branch_resolve_queue_if bus ();

  branch_resolve_queue dut (
    .i_clk    (clk),
    .i_arst_n (rst_n),
    .i_flush  (flush),
    .i_stall  (stall),
    .bus      (bus)
  );

  typedef struct {
    logic        push;
    logic [63:0] pc;
    logic        hit;
    logic [1:0]  way;
    logic [63:0] pred;
    logic        res;
    logic        br;
    logic        tk;
    logic [63:0] tgt;
    logic        stl;
    logic        fl;
    logic [2:0]  e_cnt;
    logic        e_upd;
    logic [63:0] e_tgt;
    logic [1:0]  e_way;
    logic [59:0] e_bia;
    logic [1:0]  e_idx;
    logic        e_mis;
    logic [63:0] e_rpc;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic add(input logic push, input logic [63:0] pc, input logic hit,
                     input logic [1:0] way, input logic [63:0] pred,
                     input logic res, input logic br, input logic tk, input logic [63:0] tgt,
                     input logic stl, input logic fl, input logic [2:0] e_cnt,
                     input logic e_upd, input logic [63:0] e_tgt, input logic [1:0] e_way,
                     input logic [59:0] e_bia, input logic [1:0] e_idx,
                     input logic e_mis, input logic [63:0] e_rpc);
    vec_t v;
    v.push = push; v.pc = pc; v.hit = hit; v.way = way; v.pred = pred;
    v.res = res; v.br = br; v.tk = tk; v.tgt = tgt; v.stl = stl; v.fl = fl;
    v.e_cnt = e_cnt; v.e_upd = e_upd; v.e_tgt = e_tgt; v.e_way = e_way;
    v.e_bia = e_bia; v.e_idx = e_idx; v.e_mis = e_mis; v.e_rpc = e_rpc;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    bus.i_push             = v.push;
    bus.i_push_pc          = v.pc;
    bus.i_push_hit         = v.hit;
    bus.i_push_way         = v.way;
    bus.i_push_pred_target = v.pred;
    bus.i_resolve          = v.res;
    bus.i_is_branch        = v.br;
    bus.i_taken            = v.tk;
    bus.i_actual_target    = v.tgt;
    stall                  = v.stl;
    flush                  = v.fl;
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    chk({tag, " count"}, 64'(bus.o_count), 64'(v.e_cnt));
    chk({tag, " empty"}, 64'(bus.o_empty), 64'(v.e_cnt == 3'd0));
    chk({tag, " full"},  64'(bus.o_full),  64'(v.e_cnt == 3'd4));
    chk({tag, " btb_update"}, 64'(bus.o_btb_update), 64'(v.e_upd));
    if (v.e_upd) begin
      chk({tag, " target_addr"}, bus.o_target_addr, v.e_tgt);
      chk({tag, " way_write"},   64'(bus.o_way_write), 64'(v.e_way));
      chk({tag, " bia_write"},   64'(bus.o_bia_write), 64'(v.e_bia));
      chk({tag, " index_write"}, 64'(bus.o_index_write), 64'(v.e_idx));
    end
    chk({tag, " mispredict"}, 64'(bus.o_mispredict), 64'(v.e_mis));
    if (v.e_mis) chk({tag, " redirect_pc"}, bus.o_redirect_pc, v.e_rpc);
  endtask

  task automatic apply(input string tag, input vec_t v);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    check_vec(tag, v);
  endtask

  vec_t idle;
  vec_t hv;

  initial begin
    idle = '{default: '0};
    drive(idle);

    // ---- table: fill / full / FIFO order ----
    add(1,'h1000,1,0,'h2000, 0,0,0,0,      0,0, 1, 0,0,0,0,0, 0,0);
    add(1,'h1004,1,1,'h3000, 0,0,0,0,      0,0, 2, 0,0,0,0,0, 0,0);
    add(1,'h1008,1,2,'h4000, 0,0,0,0,      0,0, 3, 0,0,0,0,0, 0,0);
    add(1,'h100C,1,3,'h5000, 0,0,0,0,      0,0, 4, 0,0,0,0,0, 0,0);
    add(1,'h1010,1,0,'h6000, 0,0,0,0,      0,0, 4, 0,0,0,0,0, 0,0);
    add(1,'h1010,1,0,'h6000, 1,1,1,'h2000, 0,0, 3, 1,'h2000,0,'h100,0, 0,0);
    add(0,0,0,0,0,           1,1,1,'h3000, 0,0, 2, 1,'h3000,1,'h100,1, 0,0);
    add(0,0,0,0,0,           1,1,1,'h4000, 0,0, 1, 1,'h4000,2,'h100,2, 0,0);
    add(0,0,0,0,0,           1,1,1,'h5000, 0,0, 0, 1,'h5000,3,'h100,3, 0,0);
    add(0,0,0,0,0,           1,1,1,'h9999, 0,0, 0, 0,0,0,0,0, 0,0);
    // ---- mispredict: not-hit taken branch clears younger entry ----
    add(1,'h1000,0,2,0,      0,0,0,0,      0,0, 1, 0,0,0,0,0, 0,0);
    add(1,'h1004,0,0,0,      0,0,0,0,      0,0, 2, 0,0,0,0,0, 0,0);
    add(0,0,0,0,0,           1,1,1,'h2000, 0,0, 0, 1,'h2000,2,'h100,0, 1,'h2000);
    add(0,0,0,0,0,           0,0,0,0,      0,0, 0, 0,0,0,0,0, 0,0);
    // ---- aliased non-branch hit ----
    add(1,'h1004,1,1,'h3000, 0,0,0,0,      0,0, 1, 0,0,0,0,0, 0,0);
    add(0,0,0,0,0,           1,0,0,0,      0,0, 0, 0,0,0,0,0, 1,'h1008);
    // ---- predicted taken, actually not taken ----
    add(1,'h2000,1,3,'h3000, 0,0,0,0,      0,0, 1, 0,0,0,0,0, 0,0);
    add(0,0,0,0,0,           1,1,0,0,      0,0, 0, 0,0,0,0,0, 1,'h2004);
    // ---- taken, wrong target ----
    add(1,'h2008,1,1,'h3000, 0,0,0,0,      0,0, 1, 0,0,0,0,0, 0,0);
    add(0,0,0,0,0,           1,1,1,'h3100, 0,0, 0, 1,'h3100,1,'h200,2, 1,'h3100);
    // ---- push dropped on same-cycle mispredict ----
    add(1,'h2010,1,0,'h2020, 0,0,0,0,      0,0, 1, 0,0,0,0,0, 0,0);
    add(1,'h2014,0,0,0,      1,0,0,0,      0,0, 0, 0,0,0,0,0, 1,'h2014);
    // ---- count 2, push+pop x6 with pointer wrap ----
    add(1,'h3000,1,0,'h3100, 0,0,0,0,      0,0, 1, 0,0,0,0,0, 0,0);
    add(1,'h3004,1,1,'h3104, 0,0,0,0,      0,0, 2, 0,0,0,0,0, 0,0);
    add(1,'h3008,1,2,'h3108, 1,1,1,'h3100, 0,0, 2, 1,'h3100,0,'h300,0, 0,0);
    add(1,'h300C,1,3,'h310C, 1,1,1,'h3104, 0,0, 2, 1,'h3104,1,'h300,1, 0,0);
    add(1,'h3010,1,0,'h3110, 1,1,1,'h3108, 0,0, 2, 1,'h3108,2,'h300,2, 0,0);
    add(1,'h3014,1,1,'h3114, 1,1,1,'h310C, 0,0, 2, 1,'h310C,3,'h300,3, 0,0);
    add(1,'h3018,1,2,'h3118, 1,1,1,'h3110, 0,0, 2, 1,'h3110,0,'h301,0, 0,0);
    add(1,'h301C,1,3,'h311C, 1,1,1,'h3114, 0,0, 2, 1,'h3114,1,'h301,1, 0,0);
    add(1,'h4000,0,0,0,      0,0,0,0,      0,1, 0, 0,0,0,0,0, 0,0);
    // ---- update held under stall, resolve blocked ----
    add(1,'h5000,1,2,'h6000, 0,0,0,0,      0,0, 1, 0,0,0,0,0, 0,0);
    add(1,'h5004,1,1,'h7000, 0,0,0,0,      0,0, 2, 0,0,0,0,0, 0,0);
    add(0,0,0,0,0,           1,1,1,'h6000, 0,0, 1, 1,'h6000,2,'h500,0, 0,0);
    add(0,0,0,0,0,           1,1,1,'h7000, 1,0, 1, 1,'h6000,2,'h500,0, 0,0);
    add(0,0,0,0,0,           1,1,1,'h7000, 1,0, 1, 1,'h6000,2,'h500,0, 0,0);
    add(0,0,0,0,0,           1,1,1,'h7000, 1,0, 1, 1,'h6000,2,'h500,0, 0,0);
    add(0,0,0,0,0,           0,0,0,0,      0,0, 1, 0,0,0,0,0, 0,0);

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    chk("reset count",      64'(bus.o_count), 64'd0);
    chk("reset empty",      64'(bus.o_empty), 64'd1);
    chk("reset full",       64'(bus.o_full), 64'd0);
    chk("reset btb_update", 64'(bus.o_btb_update), 64'd0);
    chk("reset mispredict", 64'(bus.o_mispredict), 64'd0);
    chk("reset redirect",   bus.o_redirect_pc, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) apply($sformatf("v%0d", i), vecs[i]);

    // ---- flush with same-cycle resolve still reports update + mispredict ----
    hv = '{default: '0};
    hv.res = 1; hv.br = 1; hv.tk = 1; hv.tgt = 'h7100; hv.fl = 1;
    hv.e_cnt = 0; hv.e_upd = 1; hv.e_tgt = 'h7100; hv.e_way = 1; hv.e_bia = 'h500;
    hv.e_idx = 1; hv.e_mis = 1; hv.e_rpc = 'h7100;
    apply("flush+resolve", hv);

    // ---- async reset arriving while a resolve is pending ----
    hv = '{default: '0};
    hv.push = 1; hv.pc = 'h8000; hv.way = 1; hv.e_cnt = 1;
    apply("pre-reset push", hv);
    @(negedge clk);
    bus.i_push = 1'b0; flush = 1'b0;
    bus.i_resolve = 1'b1; bus.i_is_branch = 1'b1; bus.i_taken = 1'b1;
    bus.i_actual_target = 'h9000;
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid-reset count",      64'(bus.o_count), 64'd0);
    chk("mid-reset empty",      64'(bus.o_empty), 64'd1);
    chk("mid-reset btb_update", 64'(bus.o_btb_update), 64'd0);
    chk("mid-reset mispredict", 64'(bus.o_mispredict), 64'd0);
    chk("mid-reset redirect",   bus.o_redirect_pc, 64'd0);
    @(negedge clk);
    drive(idle);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
